// File: rtl/alu_muldiv_seq.sv
// EX-stage ALU with single-cycle logic/arith ops plus iterative MULTU/DIVU.
// HI/LO are architectural; the iteration datapath uses its own accumulator.
module alu_muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    output logic [WIDTH-1:0] dataOut,
    output logic             busy,
    output logic             done,
    output logic             divZero
);

    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi, lo;
    logic [WIDTH-1:0] opd;      // multiplicand or divisor
    logic [WIDTH-1:0] acc_hi;   // partial product high / partial remainder
    logic [WIDTH-1:0] acc_lo;   // multiplier / dividend-quotient shift register

    logic [WIDTH-1:0] alu_res;
    logic [CNT_W-1:0] shamt;
    logic             slt;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_hi_nx, div_lo_nx;

    assign shamt = dataB[CNT_W-1:0];
    assign slt   = $signed(dataA) < $signed(dataB);

    always_comb begin
        alu_res = '0;
        case (Signal)
            F_AND:  alu_res = dataA & dataB;
            F_OR:   alu_res = dataA | dataB;
            F_ADD:  alu_res = dataA + dataB;
            F_SUB:  alu_res = dataA - dataB;
            F_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt};
            F_SRL:  alu_res = (32'(shamt) >= WIDTH) ? '0 : (dataA >> shamt);
            F_MFHI: alu_res = hi;
            F_MFLO: alu_res = lo;
            default: alu_res = '0;
        endcase
    end

    // Shift-add step: carry out of the add shifts into the high half.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : '0);
        mul_hi_nx = mul_sum[WIDTH:1];
        mul_lo_nx = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end

    // Restoring step: remainder stays below the divisor, so WIDTH bits hold the difference.
    always_comb begin
        div_trial = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = div_trial >= {1'b0, opd};
        div_diff  = div_trial[WIDTH-1:0] - opd;
        div_hi_nx = div_ge ? div_diff : div_trial[WIDTH-1:0];
        div_lo_nx = {acc_lo[WIDTH-2:0], div_ge};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            opd     <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            dataOut <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            divZero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (Signal)
                            F_MULTU: begin
                                opd    <= dataA;
                                acc_hi <= '0;
                                acc_lo <= dataB;
                                cnt    <= '0;
                                busy   <= 1'b1;
                                state  <= MUL;
                            end
                            F_DIVU: begin
                                if (dataB == '0) begin
                                    hi      <= dataA;
                                    lo      <= '1;
                                    dataOut <= '1;
                                    divZero <= 1'b1;
                                    done    <= 1'b1;
                                end else begin
                                    opd     <= dataB;
                                    acc_hi  <= '0;
                                    acc_lo  <= dataA;
                                    cnt     <= '0;
                                    divZero <= 1'b0;
                                    busy    <= 1'b1;
                                    state   <= DIV;
                                end
                            end
                            default: begin
                                dataOut <= alu_res;
                                done    <= 1'b1;
                            end
                        endcase
                    end
                end
                MUL: begin
                    acc_hi <= mul_hi_nx;
                    acc_lo <= mul_lo_nx;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        hi      <= mul_hi_nx;
                        lo      <= mul_lo_nx;
                        dataOut <= mul_lo_nx;
                        cnt     <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end
                end
                DIV: begin
                    acc_hi <= div_hi_nx;
                    acc_lo <= div_lo_nx;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        hi      <= div_hi_nx;
                        lo      <= div_lo_nx;
                        dataOut <= div_lo_nx;
                        cnt     <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Parametrised, clocked successor of the single-cycle datapath ALU.
- Executes the same funct-coded ops (AND, OR, ADD, SUB, SLT) and adds SRL, MULTU, DIVU, MFHI and MFLO.
- Has internal HI/LO registers and a start/busy/done handshake.
- Sits in the EX stage; the control unit holds the pipeline while busy is high.

Parameters:
- WIDTH, 32: operand/result width in bits (≥4).
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  op request; sampled only when busy=0.
- dataA  in  WIDTH  operand A (rs).
- dataB  in  WIDTH  operand B (rt); SRL uses dataB[CNT_W-1:0] as shift amount.
- Signal  in  6  funct code.
- dataOut  out  WIDTH  registered result.
- busy  out  1  multi-cycle op in progress.
- done  out  1  one-cycle pulse: dataOut/HI/LO updated.
- divZero  out  1  sticky: last DIVU had dataB=0; cleared by next accepted DIVU.

Behaviour:
- Funct codes:
  - AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010.
  - SRL 000010, MULTU 011001, DIVU 011011, MFHI 010000, MFLO 010010.
- Reset (reset=0, async): state IDLE; dataOut, HI, LO, counter, busy, done, divZero all 0.
- States: IDLE, MUL, DIV.
- Accept: start=1 and state IDLE at a rising edge. start while busy=1 is ignored, not queued.
- Single-cycle ops (AND/OR/ADD/SUB/SLT/SRL/MFHI/MFLO/unknown):
  - Result registered at the accept edge; done=1 for exactly the following cycle; state stays IDLE.
  - A back-to-back start in that done cycle is accepted.
- Arithmetic rules:
  - ADD/SUB: modulo 2^WIDTH, no overflow trap.
  - SLT: signed compare, result 1 or 0 zero-extended.
  - SRL: logical shift right by dataB[CNT_W-1:0]; shift ≥ WIDTH gives 0.
  - MFHI/MFLO: dataOut = HI / LO.
  - Unknown funct: dataOut = 0, done still pulses.
- MULTU (unsigned shift-add):
  - At accept: latch operands, clear {HI,LO} accumulator, counter = 0, busy=1, state MUL.
  - Each edge in MUL: one iteration (add multiplicand if multiplier LSB set, shift), counter+1.
  - At the edge where counter reaches WIDTH-1: final iteration done, {HI,LO} = full 2*WIDTH product, state IDLE, busy=0, done=1 next cycle.
  - Total: done high in cycle WIDTH+1 after the accept edge; dataOut = LO at that point.
- DIVU (unsigned restoring):
  - Same timing as MULTU, state DIV; LO = quotient, HI = remainder; dataOut = LO.
  - Divisor 0: no iterations; at the accept edge HI = dataA, LO = all-ones, divZero=1, done next cycle, busy never rises.
- Operand inputs may change freely after accept; internal copies are used.
- Signal changes during MUL/DIV have no effect.
- HI/LO are changed only by MULTU/DIVU completion and by reset.
- done and busy are never both 1.
- Reset asserted mid-MUL/DIV: immediate abort to IDLE; HI/LO cleared; no done pulse.
- Counter wrap-around cannot occur (terminal compare at WIDTH-1).

Test Plan:
1. reset=0, then release; start ADD, dataA=7, dataB=0xFFFFFFFF -> next cycle dataOut=6, done=1 for one cycle, busy=0.
2. SLT with dataA=0x80000000, dataB=1 -> 1. SUB 5-9 -> 0xFFFFFFFC. SRL dataA=0xF0000000 by 4 -> 0x0F000000. SRL by 40 (CNT_W=6) -> 0.
3. MULTU 0xFFFFFFFF × 2 -> busy high 32 cycles; done in cycle 33 after accept; HI=1, LO=0xFFFFFFFE. Subsequent MFHI -> 1, MFLO -> 0xFFFFFFFE. A start pulse mid-operation is ignored.
4. DIVU 100/7 -> done at cycle 33, LO=14, HI=2, divZero=0. DIVU 5/0 -> done next cycle, busy never 1, LO=0xFFFFFFFF, HI=5, divZero=1. Following DIVU 9/3 -> divZero=0.
5. reset=0 at iteration 10 of MULTU -> busy=0, HI=LO=0 immediately; no done; next ADD 1+1 -> 2.
6. Unknown funct 111111 -> dataOut=0, done pulses. Back-to-back single-cycle ops with start held high -> a result and a done pulse every cycle.
